// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point miscellaneous-op pipeline:
// default format widths, opcode encodings and the FCLASS one-hot layout.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned OP_W      = 4;

  typedef enum logic [OP_W-1:0] {
    OP_FSGNJ  = 4'd0,
    OP_FSGNJN = 4'd1,
    OP_FSGNJX = 4'd2,
    OP_FMIN   = 4'd3,
    OP_FMAX   = 4'd4,
    OP_FEQ    = 4'd5,
    OP_FLT    = 4'd6,
    OP_FLE    = 4'd7,
    OP_FCLASS = 4'd8
  } fp_op_e;

  // Field order is the FCLASS result layout: qnan is bit 9, ninf is bit 0.
  typedef struct packed {
    logic qnan;
    logic snan;
    logic pinf;
    logic pnorm;
    logic psub;
    logic pzero;
    logic nzero;
    logic nsub;
    logic nnorm;
    logic ninf;
  } fp_class_t;

  localparam int unsigned FCLASS_W = $bits(fp_class_t);

  function automatic logic cls_is_nan(input fp_class_t c);
    return c.qnan | c.snan;
  endfunction

  function automatic logic cls_is_zero(input fp_class_t c);
    return c.pzero | c.nzero;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: decodes an IEEE-754 value of the given
// exponent/mantissa widths into the one-hot FCLASS categories.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output fp_class_t            cls_o
);

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign sign     = op_i[EXP_W+MAN_W];
  assign exp_f    = op_i[MAN_W +: EXP_W];
  assign man_f    = op_i[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  always_comb begin
    cls_o       = '0;
    cls_o.qnan  = exp_ones & ~man_zero &  man_f[MAN_W-1];
    cls_o.snan  = exp_ones & ~man_zero & ~man_f[MAN_W-1];
    cls_o.pinf  = ~sign & exp_ones & man_zero;
    cls_o.ninf  =  sign & exp_ones & man_zero;
    cls_o.pnorm = ~sign & ~exp_ones & ~exp_zero;
    cls_o.nnorm =  sign & ~exp_ones & ~exp_zero;
    cls_o.psub  = ~sign & exp_zero & ~man_zero;
    cls_o.nsub  =  sign & exp_zero & ~man_zero;
    cls_o.pzero = ~sign & exp_zero & man_zero;
    cls_o.nzero =  sign & exp_zero & man_zero;
  end

endmodule

// File: rtl/fp_misc_pipe.sv
// Two-stage pipeline for sign-injection, min/max, compare and classify ops.
// Stage 1 captures operands plus their decoded classes; stage 2 holds results.
module fp_misc_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_nv,
  output logic                 out_illegal,
  input  logic                 flags_clr,
  output logic                 fflags_nv
);

  localparam int unsigned FLEN = 1 + EXP_W + MAN_W;
  localparam logic [FLEN-1:0] CANON_NAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  fp_class_t cls_a_c;
  fp_class_t cls_b_c;

  logic            s1_valid_q, s1_valid_d;
  logic [OP_W-1:0] s1_op_q, s1_op_d;
  logic [FLEN-1:0] s1_a_q, s1_a_d;
  logic [FLEN-1:0] s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  fp_class_t       s1_cls_a_q, s1_cls_a_d;
  fp_class_t       s1_cls_b_q, s1_cls_b_d;

  logic            out_valid_q, out_valid_d;
  logic [FLEN-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic            out_nv_q, out_nv_d;
  logic            out_illegal_q, out_illegal_d;
  logic            fflags_q, fflags_d;

  logic            out_free;
  logic            accept;
  logic [FLEN-1:0] res_c;
  logic            nv_c;
  logic            ill_c;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op_i(in_a), .cls_o(cls_a_c));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op_i(in_b), .cls_o(cls_b_c));

  // Output stage can take new data when empty or being drained this cycle.
  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | out_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
      s1_cls_a_d = cls_a_c;
      s1_cls_b_d = cls_b_c;
    end else if (out_free) begin
      s1_valid_d = 1'b0;
    end
  end

  logic            sign_a, sign_b;
  logic [FLEN-2:0] mag_a, mag_b;
  logic            a_nan, b_nan, a_snan, b_snan, any_nan, both_zero;
  logic            lt_raw, feq, flt, fle, pick_a;

  assign sign_a    = s1_a_q[FLEN-1];
  assign sign_b    = s1_b_q[FLEN-1];
  assign mag_a     = s1_a_q[FLEN-2:0];
  assign mag_b     = s1_b_q[FLEN-2:0];
  assign a_nan     = cls_is_nan(s1_cls_a_q);
  assign b_nan     = cls_is_nan(s1_cls_b_q);
  assign a_snan    = s1_cls_a_q.snan;
  assign b_snan    = s1_cls_b_q.snan;
  assign any_nan   = a_nan | b_nan;
  assign both_zero = cls_is_zero(s1_cls_a_q) & cls_is_zero(s1_cls_b_q);

  // Sign-magnitude ordering in which -0 sorts below +0; compares mask that out.
  assign lt_raw = (sign_a != sign_b) ? sign_a
                : (sign_a ? (mag_a > mag_b) : (mag_a < mag_b));
  assign feq    = ~any_nan & (both_zero | (s1_a_q == s1_b_q));
  assign flt    = ~any_nan & ~both_zero & lt_raw;
  assign fle    = flt | feq;
  assign pick_a = (s1_op_q == OP_FMIN) ? lt_raw : ~lt_raw;

  logic unused_cls_b;
  assign unused_cls_b = ^{s1_cls_b_q.pinf, s1_cls_b_q.pnorm, s1_cls_b_q.psub,
                          s1_cls_b_q.nsub, s1_cls_b_q.nnorm, s1_cls_b_q.ninf};

  always_comb begin
    res_c = '0;
    nv_c  = 1'b0;
    ill_c = 1'b0;
    case (s1_op_q)
      OP_FSGNJ:  res_c = {sign_b, mag_a};
      OP_FSGNJN: res_c = {~sign_b, mag_a};
      OP_FSGNJX: res_c = {sign_a ^ sign_b, mag_a};
      OP_FMIN, OP_FMAX: begin
        nv_c = a_snan | b_snan;
        if (a_nan & b_nan) begin
          res_c = CANON_NAN;
        end else if (a_nan) begin
          res_c = s1_b_q;
        end else if (b_nan) begin
          res_c = s1_a_q;
        end else begin
          res_c = pick_a ? s1_a_q : s1_b_q;
        end
      end
      OP_FEQ: begin
        nv_c  = a_snan | b_snan;
        res_c = {{(FLEN-1){1'b0}}, feq};
      end
      OP_FLT: begin
        nv_c  = any_nan;
        res_c = {{(FLEN-1){1'b0}}, flt};
      end
      OP_FLE: begin
        nv_c  = any_nan;
        res_c = {{(FLEN-1){1'b0}}, fle};
      end
      OP_FCLASS: res_c = {{(FLEN-FCLASS_W){1'b0}}, s1_cls_a_q};
      default:   ill_c = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_nv_d      = out_nv_q;
    out_illegal_d = out_illegal_q;
    if (out_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d  = res_c;
        out_tag_d     = s1_tag_q;
        out_nv_d      = nv_c;
        out_illegal_d = ill_c;
      end
    end
  end

  // Sticky flag: a set from a consumed result wins over a same-cycle clear.
  assign fflags_d = (fflags_q & ~flags_clr) | (out_valid_q & out_ready & out_nv_q);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_tag_q      <= '0;
      s1_cls_a_q    <= '0;
      s1_cls_b_q    <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_nv_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      fflags_q      <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_tag_q      <= s1_tag_d;
      s1_cls_a_q    <= s1_cls_a_d;
      s1_cls_b_q    <= s1_cls_b_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_nv_q      <= out_nv_d;
      out_illegal_q <= out_illegal_d;
      fflags_q      <= fflags_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_nv      = out_nv_q;
  assign out_illegal = out_illegal_q;
  assign fflags_nv   = fflags_q;

endmodule

// File: tb/tb_fp_misc_pipe.sv
// Scoreboard bench for fp_misc_pipe: single and double precision instances,
// expected results from a value-level reference model of the FP rules.
module tb_fp_misc_pipe;
  import fp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision instance
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        out_nv, out_illegal, flags_clr, fflags_nv;
  logic [3:0]  in_op, in_tag, out_tag;
  logic [31:0] in_a, in_b, out_result;

  fp_misc_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_nv(out_nv), .out_illegal(out_illegal),
    .flags_clr(flags_clr), .fflags_nv(fflags_nv)
  );

  // Double-precision instance
  logic        rst_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic        out_nv_w, out_illegal_w, flags_clr_w, fflags_nv_w;
  logic [3:0]  in_op_w, in_tag_w, out_tag_w;
  logic [63:0] in_a_w, in_b_w, out_result_w;

  fp_misc_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut_w (
    .CLK(clk), .RST(rst_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_op(in_op_w), .in_a(in_a_w), .in_b(in_b_w), .in_tag(in_tag_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_result(out_result_w),
    .out_tag(out_tag_w), .out_nv(out_nv_w), .out_illegal(out_illegal_w),
    .flags_clr(flags_clr_w), .fflags_nv(fflags_nv_w)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        nv;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] tag_cnt = 4'd0;
  bit         mon_en = 1'b0;
  bit         model_ff = 1'b0;
  bit         held_v = 1'b0;
  logic [37:0] held;
  bit         rand_on;

  // FCLASS bit index of a value: 9 qNaN .. 0 -inf
  function automatic int cls_idx(input int ew, input int mw, input logic [63:0] x);
    logic [63:0] emax = (64'd1 << ew) - 64'd1;
    logic [63:0] e = (x >> mw) & emax;
    logic [63:0] m = x & ((64'd1 << mw) - 64'd1);
    logic s = x[ew+mw];
    if (e == emax) begin
      if (m == 64'd0) return s ? 0 : 7;
      return m[mw-1] ? 9 : 8;
    end
    if (e == 64'd0) begin
      if (m == 64'd0) return s ? 3 : 4;
      return s ? 2 : 5;
    end
    return s ? 1 : 6;
  endfunction

  // Reference: numeric order via a signed integer key (magnitude, negated if negative)
  function automatic void ref_fp(input int ew, input int mw, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output logic nv, output logic ill);
    int sp = ew + mw;
    logic [63:0] mmask = (64'd1 << sp) - 64'd1;
    int ca = cls_idx(ew, mw, a);
    int cb = cls_idx(ew, mw, b);
    bit an = (ca >= 8);
    bit bn = (cb >= 8);
    bit as = (ca == 8);
    bit bs = (cb == 8);
    bit sa = a[sp];
    bit sbt = b[sp];
    longint ka = sa ? -longint'(a & mmask) : longint'(a & mmask);
    longint kb = sbt ? -longint'(b & mmask) : longint'(b & mmask);
    logic [63:0] canon = (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    bit a_is_min;
    res = 64'd0; nv = 1'b0; ill = 1'b0;
    case (op)
      4'd0: res = (a & mmask) | (64'(sbt) << sp);
      4'd1: res = (a & mmask) | (64'(~sbt) << sp);
      4'd2: res = (a & mmask) | (64'(sa ^ sbt) << sp);
      4'd3, 4'd4: begin
        nv = as | bs;
        if (an && bn) res = canon;
        else if (an) res = b;
        else if (bn) res = a;
        else begin
          a_is_min = (ka < kb) || (ka == kb && sa);
          res = (((op == 4'd3) ? 1'b1 : 1'b0) == a_is_min) ? a : b;
        end
      end
      4'd5: begin nv = as | bs; res = 64'(!an && !bn && ka == kb); end
      4'd6: begin nv = an | bn; res = 64'(!an && !bn && ka < kb); end
      4'd7: begin nv = an | bn; res = 64'(!an && !bn && ka <= kb); end
      4'd8: res = 64'd1 << ca;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return {r[31], 31'h7F80_0000};
      3: return {r[31], 8'hFF, 1'b1, r[21:0]};
      4: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      5: return {r[31], 8'h00, r[22:0]};
      6: return {r[31], 31'h3F80_0000};
      default: return r;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one request to the single-precision DUT; called at posedge+1
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit dir, input logic [31:0] xres, input logic xnv);
    exp_t e;
    logic [63:0] r;
    logic nv, il;
    int n;
    ref_fp(8, 23, op, {32'h0, a}, {32'h0, b}, r, nv, il);
    e.res = dir ? xres : r[31:0];
    e.nv  = dir ? xnv : nv;
    e.ill = il;
    e.tag = tag_cnt;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for op %0d", op);
    end
    @(posedge clk); #1;
    if (n < 200) sb.push_back(e);
    in_valid = 1'b0;
    tag_cnt = tag_cnt + 4'd1;
  endtask

  task automatic issue_rand();
    logic [3:0] op;
    logic [31:0] a, b;
    op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    a = pick32();
    case ($urandom_range(0, 5))
      0: b = a;
      1: b = a ^ 32'h8000_0000;
      default: b = pick32();
    endcase
    issue(op, a, b, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  // Double-precision single transaction with out_ready_w held high
  task automatic run64(input string nm, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] xres, input logic xnv,
                       input logic xill);
    int n = 0;
    logic [3:0] t = 4'($urandom_range(0, 15));
    in_valid_w = 1'b1; in_op_w = op; in_a_w = a; in_b_w = b; in_tag_w = t;
    do begin @(negedge clk); n++; end while (!in_ready_w && n < 50);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, 64'(out_valid_w), 64'd1);
    chk({nm, "_result"}, out_result_w, xres);
    chk({nm, "_nv"}, 64'(out_nv_w), 64'(xnv));
    chk({nm, "_illegal"}, 64'(out_illegal_w), 64'(xill));
    chk({nm, "_tag"}, 64'(out_tag_w), 64'(t));
    @(posedge clk); #1;
  endtask

  // Monitor: handshake, stall stability, sticky flag and scoreboard compare
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit cons_nv;
      cons_nv = 1'b0;
      checks++;
      if (in_ready !== !(sb.size() == 2 && !out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b with %0d in flight, out_ready %b", in_ready, sb.size(), out_ready);
      end
      checks++;
      if (fflags_nv !== model_ff) begin
        errors++;
        $display("FAIL fflags_nv: got %b expected %b", fflags_nv, model_ff);
      end
      if (out_valid && held_v) begin
        checks++;
        if ({out_result, out_tag, out_nv, out_illegal} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h", {out_result, out_tag, out_nv, out_illegal}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: result %h tag %0d with nothing outstanding", out_result, out_tag);
        end else begin
          e = sb.pop_front();
          cons_nv = e.nv;
          if (out_result !== e.res || out_tag !== e.tag || out_nv !== e.nv || out_illegal !== e.ill) begin
            errors++;
            $display("FAIL result: got res %h tag %0d nv %b ill %b expected res %h tag %0d nv %b ill %b",
                     out_result, out_tag, out_nv, out_illegal, e.res, e.tag, e.nv, e.ill);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_result, out_tag, out_nv, out_illegal};
      model_ff = (model_ff && !flags_clr) || cons_nv;
    end
  end

  initial begin
    logic [63:0] r;
    logic nv, il;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 4'd0;
    out_ready = 1'b1; flags_clr = 1'b0;
    rst_w = 1'b0; in_valid_w = 1'b0; in_op_w = 4'd0; in_a_w = 64'd0; in_b_w = 64'd0;
    in_tag_w = 4'd0; out_ready_w = 1'b1; flags_clr_w = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; rst_w = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_nv_ill", 64'({out_nv, out_illegal}), 64'd0);
    chk("rst_fflags", 64'(fflags_nv), 64'd0);
    chk("rst_w_valid_ready", 64'({out_valid_w, in_ready_w}), 64'b01);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Min of -0/+0 with latency measurement
    tag_cnt = 4'd3;
    issue(OP_FMIN, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    drain();

    issue(OP_FMAX, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b1);
    drain();
    chk("fflags_set", 64'(fflags_nv), 64'd1);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    chk("fflags_clr", 64'(fflags_nv), 64'd0);

    issue(OP_FLT, 32'h7FC0_0000, 32'h0000_0000, 1'b1, 32'h0, 1'b1);
    issue(OP_FEQ, 32'h7FC0_0000, 32'h0000_0000, 1'b1, 32'h0, 1'b0);
    issue(OP_FCLASS, 32'hFF80_0000, 32'h0, 1'b1, 32'h0000_0001, 1'b0);
    issue(OP_FCLASS, 32'h0000_0001, 32'h0, 1'b1, 32'h0000_0020, 1'b0);
    issue(OP_FSGNJX, 32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'hBF80_0000, 1'b0);
    issue(4'd12, 32'h1234_5678, 32'h1, 1'b1, 32'h0, 1'b0);
    drain();

    // Back-to-back stream with a four-cycle output stall
    tag_cnt = 4'd0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(4'($urandom_range(0, 8)), pick32(), pick32(), 1'b0, 32'h0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random back-pressure
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          issue_rand();
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Double precision
    run64("w_fmin_qnan", OP_FMIN, 64'h7FF8_0000_0000_0000, 64'hFFF8_0000_0000_1234,
          64'h7FF8_0000_0000_0000, 1'b0, 1'b0);
    run64("w_illegal", 4'd12, 64'h3FF0_0000_0000_0000, 64'h1, 64'h0, 1'b0, 1'b1);
    ref_fp(11, 52, OP_FCLASS, 64'hFFF0_0000_0000_0000, 64'h0, r, nv, il);
    run64("w_fclass_ninf", OP_FCLASS, 64'hFFF0_0000_0000_0000, 64'h0, r, nv, il);
    ref_fp(11, 52, OP_FLT, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, r, nv, il);
    run64("w_flt", OP_FLT, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, r, nv, il);
    ref_fp(11, 52, OP_FMAX, 64'h8000_0000_0000_0000, 64'h0, r, nv, il);
    run64("w_fmax_zero", OP_FMAX, 64'h8000_0000_0000_0000, 64'h0, r, nv, il);
    ref_fp(11, 52, OP_FMIN, 64'h7FF0_0000_0000_0001, 64'hBFF0_0000_0000_0000, r, nv, il);
    run64("w_fmin_snan", OP_FMIN, 64'h7FF0_0000_0000_0001, 64'hBFF0_0000_0000_0000, r, nv, il);

    // Reset with two requests in flight, output held back
    out_ready_w = 1'b0;
    in_valid_w = 1'b1; in_op_w = OP_FSGNJ; in_a_w = 64'h1; in_b_w = 64'h2; in_tag_w = 4'd5;
    @(posedge clk); #1;
    in_tag_w = 4'd6;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    rst_w = 1'b0;
    @(posedge clk); #1;
    rst_w = 1'b1;
    out_ready_w = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_w) n++;
    end
    chk("w_reset_flush", 64'(n), 64'd0);
    chk("w_reset_ready", 64'(in_ready_w), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_misc_pipe.md
FP_MISC_PIPE -- requirements
Module: fp_misc_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; FLEN = 1+EXP_W+MAN_W (32 default, 64 with 11/52).
REQ-003 SHALL have parameter TAG_W, default 4, request tag width.
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  request valid.
REQ-007 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-008 in_op  in  4  0 FSGNJ, 1 FSGNJN, 2 FSGNJX, 3 FMIN, 4 FMAX, 5 FEQ, 6 FLT, 7 FLE, 8 FCLASS; 9-15 illegal.
REQ-009 in_a, in_b  in  FLEN  operands rs1, rs2 (in_b ignored for FCLASS).
REQ-010 in_tag  in  TAG_W  returned unchanged with result.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-013 out_result  out  FLEN  result.
REQ-014 out_tag  out  TAG_W  tag of this result.
REQ-015 out_nv  out  1  invalid-operation flag of this result.
REQ-016 out_illegal  out  1  request had illegal opcode.
REQ-017 flags_clr  in  1  one-cycle pulse clearing sticky flag.
REQ-018 fflags_nv  out  1  sticky OR of out_nv over all consumed results.

Function
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers operands, op, tag and decoded class bits; stage 2 registers result, tag, nv, illegal.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 per cycle.
REQ-021 Each stage SHALL advance when empty or when downstream consumes; in_ready = !s1_valid || s1 advancing (combinational from out_ready, no bubble).
REQ-022 Stalled out_valid SHALL hold out_result/out_tag/out_nv/out_illegal stable until consumed; no request dropped or duplicated.
REQ-023 FSGNJ/FSGNJN/FSGNJX: magnitude of a, sign = b.sign / ~b.sign / a.sign^b.sign; never raise nv.
REQ-024 FMIN/FMAX: -0 < +0; one NaN returns the other operand; both NaN returns canonical NaN (sign 0, exponent all ones, mantissa MSB only); nv=1 if either is sNaN.
REQ-025 FEQ: nv=1 only for sNaN operand; FLT/FLE: nv=1 for any NaN operand; NaN compare gives 0; +0 == -0; result 1/0 zero-extended to FLEN.
REQ-026 FCLASS: 10-bit one-hot {qNaN,sNaN,+inf,+normal,+subnormal,+0,-0,-subnormal,-normal,-inf} bits 9..0, zero-extended; nv=0.
REQ-027 Illegal op: out_result=0, out_nv=0, out_illegal=1, tag returned.
REQ-028 fflags_nv SHALL set on the cycle after consumption of a result with out_nv=1; flags_clr clears it; simultaneous clr and set -> fflags_nv=1.

Reset
REQ-029 RST low at rising edge SHALL clear both stage valids, out_valid, out_result, out_tag, out_nv, out_illegal, fflags_nv to 0; in_ready=1 in the first cycle after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight requests; no result emitted for them.

Structure
REQ-031 Opcode encodings, FCLASS bit positions and default EXP_W/MAN_W SHALL live in shared package fp_pkg.
REQ-032 Operand classification SHALL be sub-module fp_classify (combinational, parameterised EXP_W/MAN_W), instantiated twice.

Verification
REQ-033 FMIN a=0x80000000, b=0x00000000, tag 3, out_ready=1 -> 2 cycles later out_result=0x80000000, out_tag=3, out_nv=0.
REQ-034 FMAX a=0x7F800001 (sNaN), b=0x3F800000 -> out_result=0x3F800000, out_nv=1, fflags_nv=1 next cycle; flags_clr -> 0.
REQ-035 FLT a=0x7FC00000, b=0x00000000 -> out_result=0, out_nv=1; FEQ same operands -> out_result=0, out_nv=0.
REQ-036 FCLASS a=0xFF800000 -> 0x00000001; a=0x00000001 -> 0x00000020; FSGNJX a=0x3F800000, b=0xBF800000 -> 0xBF800000.
REQ-037 Stream 8 back-to-back requests, out_ready low cycles 3-6 -> all 8 results in order, tags 0-7, outputs stable while stalled, in_ready low once both stages full.
REQ-038 EXP_W=11, MAN_W=52: FMIN of two qNaNs -> 0x7FF8000000000000; op=12 -> out_illegal=1, out_result=0; RST low with 2 in flight -> no outputs.
